crank_wheel_gen: RTL and testbench
==================================

# crank_wheel_gen

Synthesizable missing-tooth crank wheel generator: produces the digital `vrin` waveform that the `sync` decoder consumes, for runtime-configured tooth count, missing-tooth count and tooth period. It is the transmit end of the crank-sync interface, used for on-chip self-test and bench stimulation, with `vrin` muxed ahead of `sync` in place of the VR conditioner input. Tooth 0 is the first real tooth after the gap, matching the decoder's phase-0 convention.

## Interface
- `TOOTH_W`, 8: width of tooth count/index fields.
- `PERIOD_W`, 24: width of tooth period in clk cycles.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  level; 1 = run wheel, 0 = stop.
- `tooth_count`  in  TOOTH_W  total slots per revolution (e.g. 60).
- `missing_count`  in  TOOTH_W  missing slots at end of revolution (e.g. 2).
- `tooth_period`  in  PERIOD_W  slot length in clk cycles.
- `vrin`  out  1  generated tooth signal.
- `running`  out  1  1 while in RUN.
- `tooth_idx`  out  TOOTH_W  current slot index, 0..tooth_count-1.
- `rev_pulse`  out  1  one-cycle strobe on the first cycle of slot 0.
- `cfg_err`  out  1  sticky; set on invalid config, cleared on next valid start.

## Operation
- States: IDLE, RUN. Reset → IDLE; all outputs 0, counters 0, shadow config 0.
- Config valid iff tooth_count ≥ 3, 1 ≤ missing_count ≤ tooth_count−2, tooth_period ≥ 4.
- IDLE: enable=1 → latch inputs into shadow regs; if valid → RUN at slot 0, cycle 0, cfg_err←0; else stay IDLE, cfg_err←1.
- RUN: cyc_cnt counts 0..P−1 (P = shadow period); on wrap, slot advances; slot T−1 wraps to 0.
- Real teeth: slots 0..T−M−1. In a real slot vrin=1 while cyc_cnt < P>>1, else 0. Missing slots: vrin=0 throughout.
- Shadow config reloads from inputs only at the slot T−1 → 0 boundary; mid-revolution input changes are ignored. Invalid config at reload → IDLE, cfg_err←1, vrin←0.
- enable=0 in RUN: complete current slot, then IDLE at the slot boundary; vrin follows the normal pattern until then.
- enable re-asserted before that boundary: stop is cancelled and running continues uninterrupted.
- Reset mid-operation: immediate IDLE, all outputs 0, no partial pulse afterwards.
- Arithmetic: cyc_cnt is PERIOD_W unsigned; half-period is P>>1 (floor); slot compare is TOOTH_W unsigned; T−M is computed in TOOTH_W without underflow, guaranteed by validity.

## Timing
- All outputs registered.
- enable sampled high in IDLE at edge N → running=1, vrin=1, tooth_idx=0, rev_pulse=1 at edge N+1.
- vrin high P>>1 cycles, low P−(P>>1) cycles per real tooth; gap low run = (M·P) + P−(P>>1).
- tooth_idx changes on the same edge as the slot's first vrin cycle.
- rev_pulse high exactly 1 cycle per revolution; period T·P cycles.
- Stop: running falls on the edge after the last cycle of the current slot.

## Structure
- Shared package `efi_pkg`: TOOTH_W, PERIOD_W defaults, state enum (IDLE/RUN), config-validity function shared with `sync` test code.
- One sub-module: `tooth_timer` (period counter with wrap strobe and half-period compare); slot counter, FSM and shadow regs stay in top.

## Test plan
- 60/2, P=1000, enable at t0 → vrin 500 high/500 low ×58, then 2500 low; rev_pulse every 60000 cycles; `sync` asserts synced within 2 revolutions.
- 36/1, P=5 (odd) → high 2, low 3 per tooth; gap low 8 cycles; tooth_idx 0..35 wraps.
- Change P 1000→2000 at tooth 20 → current revolution stays 1000; new period starts exactly at next rev_pulse.
- missing_count=59 with tooth_count=60 at start → stays IDLE, cfg_err=1, vrin=0; valid config next → RUN, cfg_err=0.
- enable=0 at cycle 300 of tooth 10 → pattern continues to end of slot 10, then running=0, vrin=0; enable=1 at cycle 900 of the same slot → no stop.
- rst pulse mid-tooth (vrin=1) → vrin=0, running=0, tooth_idx=0 immediately; restart begins at slot 0.

Source files
------------

// File: rtl/efi_pkg.sv
// Shared crank-wheel definitions: default field widths, wheel state encoding
// and the configuration validity rule used by generator and decoder tests.
package efi_pkg;

  localparam int unsigned DEF_TOOTH_W  = 8;
  localparam int unsigned DEF_PERIOD_W = 24;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } wheel_state_e;

  // A wheel needs at least one real tooth beyond the sync reference and a
  // period long enough to give distinct high and low phases.
  function automatic logic cfg_valid(input logic [31:0] tooth_count,
                                     input logic [31:0] missing_count,
                                     input logic [31:0] tooth_period);
    cfg_valid = (tooth_count >= 32'd3) &&
                (missing_count >= 32'd1) &&
                (missing_count <= tooth_count - 32'd2) &&
                (tooth_period >= 32'd4);
  endfunction

endpackage

// File: rtl/crank_wheel_gen_tooth_timer.sv
// Slot period counter: counts 0..period-1 while running, flags the last cycle
// of the slot and whether the current cycle lies in the tooth's high half.
module tooth_timer
  import efi_pkg::*;
#(
  parameter int unsigned PERIOD_W = DEF_PERIOD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  output logic [PERIOD_W-1:0] cyc,
  output logic                wrap_c,
  output logic                first_half_c
);

  logic [PERIOD_W-1:0] cyc_q;
  logic [PERIOD_W-1:0] cyc_d;

  always_comb begin
    wrap_c       = run && (cyc_q == period - PERIOD_W'(1));
    first_half_c = cyc_q < (period >> 1);
    cyc_d        = '0;
    if (run && !wrap_c) begin
      cyc_d = cyc_q + PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign cyc = cyc_q;

endmodule

// File: rtl/crank_wheel_gen.sv
// Missing-tooth crank wheel generator: drives the vrin tooth pattern for a
// runtime-configured wheel, with shadow config reloaded once per revolution.
module crank_wheel_gen
  import efi_pkg::*;
#(
  parameter int unsigned TOOTH_W  = DEF_TOOTH_W,
  parameter int unsigned PERIOD_W = DEF_PERIOD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [TOOTH_W-1:0]  tooth_count,
  input  logic [TOOTH_W-1:0]  missing_count,
  input  logic [PERIOD_W-1:0] tooth_period,
  output logic                vrin,
  output logic                running,
  output logic [TOOTH_W-1:0]  tooth_idx,
  output logic                rev_pulse,
  output logic                cfg_err
);

  wheel_state_e        state_q, state_d;
  logic [TOOTH_W-1:0]  teeth_q, teeth_d;
  logic [TOOTH_W-1:0]  missing_q, missing_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [TOOTH_W-1:0]  slot_q, slot_d;
  logic                err_q, err_d;

  logic                vrin_q, vrin_d;
  logic                running_q, running_d;
  logic [TOOTH_W-1:0]  tooth_idx_q, tooth_idx_d;
  logic                rev_pulse_q, rev_pulse_d;
  logic                cfg_err_q, cfg_err_d;

  logic                run_c;
  logic                wrap_c;
  logic                first_half_c;
  logic [PERIOD_W-1:0] cyc;
  logic                cfg_ok_c;
  logic                last_slot_c;
  logic [TOOTH_W-1:0]  real_teeth_c;

  assign run_c        = (state_q == RUN);
  assign cfg_ok_c     = cfg_valid(32'(tooth_count), 32'(missing_count), 32'(tooth_period));
  assign last_slot_c  = (slot_q == teeth_q - TOOTH_W'(1));
  assign real_teeth_c = teeth_q - missing_q;

  tooth_timer #(
    .PERIOD_W(PERIOD_W)
  ) u_tooth_timer (
    .clk         (clk),
    .rst         (rst),
    .run         (run_c),
    .period      (period_q),
    .cyc         (cyc),
    .wrap_c      (wrap_c),
    .first_half_c(first_half_c)
  );

  // Sequencing: start, per-slot advance, revolution reload and orderly stop.
  always_comb begin
    state_d   = state_q;
    teeth_d   = teeth_q;
    missing_d = missing_q;
    period_d  = period_q;
    slot_d    = slot_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (enable) begin
          teeth_d   = tooth_count;
          missing_d = missing_count;
          period_d  = tooth_period;
          slot_d    = '0;
          if (cfg_ok_c) begin
            state_d = RUN;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (wrap_c) begin
          if (!enable) begin
            state_d = IDLE;
            slot_d  = '0;
          end else if (last_slot_c) begin
            teeth_d   = tooth_count;
            missing_d = missing_count;
            period_d  = tooth_period;
            slot_d    = '0;
            if (!cfg_ok_c) begin
              state_d = IDLE;
              err_d   = 1'b1;
            end
          end else begin
            slot_d = slot_q + TOOTH_W'(1);
          end
        end
      end
    endcase
  end

  // Output stage: every visible signal is one register after the wheel state.
  always_comb begin
    running_d   = run_c;
    vrin_d      = run_c && (slot_q < real_teeth_c) && first_half_c;
    tooth_idx_d = run_c ? slot_q : '0;
    rev_pulse_d = run_c && (slot_q == '0) && (cyc == '0);
    cfg_err_d   = err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      teeth_q     <= '0;
      missing_q   <= '0;
      period_q    <= '0;
      slot_q      <= '0;
      err_q       <= 1'b0;
      vrin_q      <= 1'b0;
      running_q   <= 1'b0;
      tooth_idx_q <= '0;
      rev_pulse_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      teeth_q     <= teeth_d;
      missing_q   <= missing_d;
      period_q    <= period_d;
      slot_q      <= slot_d;
      err_q       <= err_d;
      vrin_q      <= vrin_d;
      running_q   <= running_d;
      tooth_idx_q <= tooth_idx_d;
      rev_pulse_q <= rev_pulse_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign vrin      = vrin_q;
  assign running   = running_q;
  assign tooth_idx = tooth_idx_q;
  assign rev_pulse = rev_pulse_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_crank_wheel_gen.sv
// Self-checking bench for crank_wheel_gen: revolution-level reference model
// compared every cycle, plus a config table and directed corner sequences.
module tb_crank_wheel_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  tooth_count;
  logic [7:0]  missing_count;
  logic [23:0] tooth_period;
  logic        vrin;
  logic        running;
  logic [7:0]  tooth_idx;
  logic        rev_pulse;
  logic        cfg_err;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference wheel: position is a single count k within the revolution.
  bit          m_run = 1'b0;
  bit          m_err = 1'b0;
  int unsigned m_t = 0, m_m = 0, m_p = 0, m_k = 0;

  typedef struct {
    int unsigned t;
    int unsigned m;
    int unsigned p;
    bit          run;
    bit          err;
  } cfg_vec_t;

  crank_wheel_gen dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .tooth_count  (tooth_count),
    .missing_count(missing_count),
    .tooth_period (tooth_period),
    .vrin         (vrin),
    .running      (running),
    .tooth_idx    (tooth_idx),
    .rev_pulse    (rev_pulse),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic bit ref_valid(input int unsigned t, input int unsigned m, input int unsigned p);
    return (t > 2) && (m > 0) && (m + 2 <= t) && (p > 3);
  endfunction

  task automatic ref_load();
    m_t = tooth_count;
    m_m = missing_count;
    m_p = tooth_period;
  endtask

  // Advance the reference by one clock, using the inputs present at that edge.
  task automatic model_edge();
    if (!m_run) begin
      if (enable) begin
        ref_load();
        if (ref_valid(m_t, m_m, m_p)) begin
          m_run = 1'b1;
          m_k   = 0;
          m_err = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
    end else if (m_k % m_p == m_p - 1) begin
      if (!enable) begin
        m_run = 1'b0;
        m_k   = 0;
      end else if (m_k == m_t * m_p - 1) begin
        ref_load();
        m_k = 0;
        if (!ref_valid(m_t, m_m, m_p)) begin
          m_run = 1'b0;
          m_err = 1'b1;
        end
      end else begin
        m_k++;
      end
    end else begin
      m_k++;
    end
  endtask

  // One clock: outputs after the edge reflect the reference before the edge.
  task automatic tick();
    bit          xv, xr, xp, xe;
    int unsigned xi;
    xr = m_run;
    xe = m_err;
    xv = 1'b0;
    xp = 1'b0;
    xi = 0;
    if (m_run) begin
      xi = m_k / m_p;
      xv = (m_k / m_p < m_t - m_m) && (m_k % m_p < m_p / 2);
      xp = (m_k == 0);
    end
    model_edge();
    @(posedge clk);
    #1;
    check("vrin", 32'(vrin), 32'(xv));
    check("running", 32'(running), 32'(xr));
    check("tooth_idx", 32'(tooth_idx), xi);
    check("rev_pulse", 32'(rev_pulse), 32'(xp));
    check("cfg_err", 32'(cfg_err), 32'(xe));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_vrin", 32'(vrin), 0);
    check("rst_running", 32'(running), 0);
    check("rst_tooth_idx", 32'(tooth_idx), 0);
    check("rst_rev_pulse", 32'(rev_pulse), 0);
    check("rst_cfg_err", 32'(cfg_err), 0);
    m_run = 1'b0; m_err = 1'b0; m_k = 0; m_t = 0; m_m = 0; m_p = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_cfg(input int unsigned t, input int unsigned m, input int unsigned p);
    tooth_count   = 8'(t);
    missing_count = 8'(m);
    tooth_period  = 24'(p);
  endtask

  task automatic start(input int unsigned t, input int unsigned m, input int unsigned p);
    set_cfg(t, m, p);
    enable = 1'b1;
    tick();
    check("start_latency", 32'(running), 0);
    tick();
  endtask

  task automatic wait_idx(input int unsigned idx, input string tag);
    int n = 0;
    while (tooth_idx != 8'(idx) && n < 20000) begin
      tick();
      n++;
    end
    check(tag, 32'(tooth_idx), idx);
  endtask

  task automatic drain(input int unsigned cycles);
    enable = 1'b0;
    repeat (cycles) tick();
    check("drain_idle", 32'(running), 0);
  endtask

  initial begin
    cfg_vec_t    vecs[12];
    int unsigned n, hi, lo, mx, zeros;
    bit          changed;

    vecs[0]  = '{t: 3,   m: 1,   p: 4,  run: 1'b1, err: 1'b0};
    vecs[1]  = '{t: 2,   m: 1,   p: 4,  run: 1'b0, err: 1'b1};
    vecs[2]  = '{t: 60,  m: 59,  p: 10, run: 1'b0, err: 1'b1};
    vecs[3]  = '{t: 60,  m: 58,  p: 10, run: 1'b1, err: 1'b0};
    vecs[4]  = '{t: 60,  m: 0,   p: 10, run: 1'b0, err: 1'b1};
    vecs[5]  = '{t: 10,  m: 2,   p: 3,  run: 1'b0, err: 1'b1};
    vecs[6]  = '{t: 10,  m: 2,   p: 4,  run: 1'b1, err: 1'b0};
    vecs[7]  = '{t: 255, m: 253, p: 5,  run: 1'b1, err: 1'b0};
    vecs[8]  = '{t: 0,   m: 0,   p: 0,  run: 1'b0, err: 1'b1};
    vecs[9]  = '{t: 36,  m: 1,   p: 5,  run: 1'b1, err: 1'b0};
    vecs[10] = '{t: 4,   m: 2,   p: 7,  run: 1'b1, err: 1'b0};
    vecs[11] = '{t: 4,   m: 3,   p: 7,  run: 1'b0, err: 1'b1};

    enable = 1'b0;
    set_cfg(60, 2, 100);
    do_reset();
    repeat (3) tick();

    // Configuration table: start, compare against hand-derived outcome, stop.
    foreach (vecs[i]) begin
      start(vecs[i].t, vecs[i].m, vecs[i].p);
      check("tbl_running", 32'(running), 32'(vecs[i].run));
      check("tbl_cfg_err", 32'(cfg_err), 32'(vecs[i].err));
      check("tbl_vrin", 32'(vecs[i].run ? vrin : !vrin), 1);
      check("tbl_idx", 32'(tooth_idx), 0);
      n = vecs[i].run ? vecs[i].t * vecs[i].p + 5 : 3;
      if (n > 400) n = 400;
      repeat (n) tick();
      drain(vecs[i].p + 3);
    end

    // 36-1 wheel with odd period: 2 high, 3 low, gap low 8, revolution 180.
    start(36, 1, 5);
    check("w36_rev0", 32'(rev_pulse), 1);
    hi = 0;
    while (vrin && hi < 50) begin hi++; tick(); end
    check("w36_high_len", hi, 2);
    lo = 0;
    while (!vrin && lo < 50) begin lo++; tick(); end
    check("w36_low_len", lo, 3);
    wait_idx(34, "w36_idx34");
    n = 0;
    while (vrin && n < 50) begin n++; tick(); end
    lo = 0;
    while (!vrin && lo < 100) begin lo++; tick(); end
    check("w36_gap_len", lo, 8);
    check("w36_wrap_idx", 32'(tooth_idx), 0);
    check("w36_wrap_rev", 32'(rev_pulse), 1);
    n = 0; mx = 0;
    do begin
      tick();
      n++;
      if (tooth_idx > mx) mx = tooth_idx;
    end while (!rev_pulse && n < 1000);
    check("w36_rev_period", n, 180);
    check("w36_max_idx", mx, 35);
    drain(8);

    // Period change mid-revolution takes effect at the next revolution only.
    start(60, 2, 20);
    n = 0; changed = 1'b0;
    do begin
      tick();
      n++;
      if (!changed && tooth_idx == 8'd20) begin
        tooth_period = 24'd40;
        changed = 1'b1;
      end
    end while (!rev_pulse && n < 10000);
    check("pchg_old_rev", n, 1200);
    n = 0;
    do begin tick(); n++; end while (!rev_pulse && n < 10000);
    check("pchg_new_rev", n, 2400);
    drain(45);

    // 60-2 wheel, P=100: cancelled stop, then a real stop at end of slot 10.
    start(60, 2, 100);
    wait_idx(10, "stop_idx10");
    repeat (30) tick();
    enable = 1'b0;
    zeros = 0;
    repeat (60) begin tick(); if (!running) zeros++; end
    enable = 1'b1;
    while (tooth_idx != 8'd11 && zeros < 1000) begin
      tick();
      if (!running) zeros++;
    end
    check("cancel_no_stop", zeros, 0);
    wait_idx(0, "stop_idx0");
    n = 0;
    do begin tick(); n++; end while (!rev_pulse && n < 10000);
    check("w60_rev_period", n, 6000);
    wait_idx(57, "w60_idx57");
    while (tooth_idx == 8'd57 && vrin) tick();
    lo = 0;
    while (!vrin && lo < 1000) begin lo++; tick(); end
    check("w60_gap_len", lo, 250);
    wait_idx(10, "stop_idx10b");
    repeat (30) tick();
    enable = 1'b0;
    n = 0;
    while (running && n < 500) begin tick(); n++; end
    check("stop_latency", n, 70);
    check("stop_vrin", 32'(vrin), 0);
    check("stop_idx", 32'(tooth_idx), 0);

    // Asynchronous reset while a tooth is high, then a clean restart.
    start(60, 2, 100);
    wait_idx(5, "rst_idx5");
    repeat (10) tick();
    check("rst_pre_vrin", 32'(vrin), 1);
    do_reset();
    tick();
    tick();
    check("restart_running", 32'(running), 1);
    check("restart_idx", 32'(tooth_idx), 0);
    check("restart_rev", 32'(rev_pulse), 1);

    // Invalid config picked up at the revolution boundary stops the wheel.
    wait_idx(20, "bad_idx20");
    missing_count = 8'd59;
    n = 0;
    while (running && n < 10000) begin tick(); n++; end
    check("bad_reload_latency", n, 4000);
    check("bad_reload_err", 32'(cfg_err), 1);
    check("bad_reload_vrin", 32'(vrin), 0);
    missing_count = 8'd2;
    tick();
    tick();
    check("recover_running", 32'(running), 1);
    check("recover_err", 32'(cfg_err), 0);
    drain(105);

    // Randomized wheels, enable blips and config changes against the model.
    for (int it = 0; it < 10; it++) begin
      int unsigned t, m, p;
      t = $urandom_range(24, 3);
      m = $urandom_range(t - 2, 1);
      p = $urandom_range(9, 4);
      if ($urandom_range(4, 0) == 0) m = t - 1;
      set_cfg(t, m, p);
      enable = 1'b1;
      repeat ($urandom_range(400, 50)) begin
        if ($urandom_range(99, 0) < 3) enable = !enable;
        if ($urandom_range(199, 0) == 0) begin
          t = $urandom_range(24, 3);
          m = $urandom_range(t - 1, 0);
          p = $urandom_range(9, 3);
          set_cfg(t, m, p);
        end
        tick();
      end
      drain(20);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
